des_cbc_ctrl: RTL

DES_CBC_CTRL -- requirements
Module: des_cbc_ctrl

---
 rtl/des_ctrl_pkg.sv | 20 ++
 rtl/des_cbc_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the DES CBC/ECB block controller.
package des_ctrl_pkg;

    localparam int BLK_W           = 64;
    localparam int TIMEOUT_CYC_DEF = 64;
    localparam int TMO_CNT_W       = $clog2(TIMEOUT_CYC_DEF + 1);

    typedef logic [BLK_W-1:0] blk_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_REQ,
        S_KEY_WAIT,
        S_READY,
        S_ISSUE,
        S_WAIT_OUT,
        S_HOLD
    } state_t;

endpackage

// File: rtl/des_cbc_ctrl.sv
// Sequencer for a DES core: key load, one block in flight,
// CBC/ECB chaining and a response timeout.
module des_cbc_ctrl
    import des_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BLK_W-1:0] cfg_key,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic             cfg_encrypt,
    input  logic             cfg_cbc,
    input  logic             cfg_start,
    output logic             cfg_busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             err_timeout,
    output logic             core_encrypt,
    output logic [BLK_W-1:0] core_keys_64,
    output logic             core_change_keys_en,
    input  logic             core_subkeys_valid,
    output logic             core_data_en,
    output logic [BLK_W-1:0] core_data_64,
    input  logic [BLK_W-1:0] core_data_out,
    input  logic             core_out_valid
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q;
    state_t           state_d;
    blk_t             key_q;
    blk_t             chain_q;
    blk_t             blk_q;
    blk_t             out_q;
    logic             enc_q;
    logic             cbc_q;
    logic             err_q;
    logic             low_seen_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cfg_take;
    logic             blk_take;

    assign cfg_take = cfg_start
                   && (state_q == S_IDLE || state_q == S_READY);
    assign blk_take = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) state_d = S_KEY_REQ;
            end
            S_KEY_REQ: begin
                state_d = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                // only a schedule that went low after our request counts
                if (low_seen_q && core_subkeys_valid) state_d = S_READY;
            end
            S_READY: begin
                if (cfg_start)     state_d = S_KEY_REQ;
                else if (in_valid) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT_OUT;
            end
            S_WAIT_OUT: begin
                if (core_out_valid)         state_d = S_HOLD;
                else if (cnt_q == CNT_LAST) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (out_ready) state_d = S_READY;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cfg_busy            = 1'b0;
        in_ready            = 1'b0;
        out_valid           = 1'b0;
        core_change_keys_en = 1'b0;
        core_data_en        = 1'b0;
        unique case (state_q)
            S_KEY_REQ: begin
                cfg_busy            = 1'b1;
                core_change_keys_en = 1'b1;
            end
            S_KEY_WAIT: cfg_busy     = 1'b1;
            S_READY:    in_ready     = !cfg_start;
            S_ISSUE:    core_data_en = 1'b1;
            S_HOLD:     out_valid    = 1'b1;
            default:    cfg_busy     = 1'b0;
        endcase
    end

    assign out_data     = out_q;
    assign err_timeout  = err_q;
    assign core_encrypt = enc_q;
    assign core_keys_64 = key_q;
    assign core_data_64 = (cbc_q && enc_q) ? (blk_q ^ chain_q) : blk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q      <= '0;
            chain_q    <= '0;
            blk_q      <= '0;
            out_q      <= '0;
            enc_q      <= 1'b0;
            cbc_q      <= 1'b0;
            err_q      <= 1'b0;
            low_seen_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (cfg_take) begin
                key_q   <= cfg_key;
                chain_q <= cfg_iv;
                enc_q   <= cfg_encrypt;
                cbc_q   <= cfg_cbc;
                err_q   <= 1'b0;
            end
            if (state_q == S_KEY_REQ) begin
                low_seen_q <= 1'b0;
            end else if (state_q == S_KEY_WAIT && !core_subkeys_valid) begin
                low_seen_q <= 1'b1;
            end
            if (blk_take) begin
                blk_q <= in_data;
            end
            if (state_q == S_ISSUE) begin
                cnt_q <= '0;
            end
            if (state_q == S_WAIT_OUT) begin
                if (core_out_valid) begin
                    if (cbc_q && enc_q) begin
                        out_q   <= core_data_out;
                        chain_q <= core_data_out;
                    end else if (cbc_q) begin
                        out_q   <= core_data_out ^ chain_q;
                        chain_q <= blk_q;
                    end else begin
                        out_q <= core_data_out;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) err_q <= 1'b1;
                end
            end
        end
    end

endmodule
